// File: rtl/regfile_mp.sv
// Multi-ported register file with combinational reads, writeback bypass and a
// per-register busy scoreboard for in-flight producers.
module regfile_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 4,
  parameter int unsigned NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR-1:0]        set_en,
  input  logic [NUM_WR*ADDR_W-1:0] set_addr,
  input  logic                     flush
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0]   r_mem [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // Busy next state: retire clears first, then younger issues set, flush overrides all.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < int'(NUM_WR); j++) begin
      if (wr_en[j]) begin
        w_busy_nxt[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    for (int j = 0; j < int'(NUM_WR); j++) begin
      if (set_en[j]) begin
        w_busy_nxt[set_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
      end
    end
    if (flush) begin
      w_busy_nxt = '0;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // State update; ascending port order lets the highest writing port win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      for (int k = 0; k < int'(NUM_REGS); k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      r_busy <= w_busy_nxt;
      for (int j = 0; j < int'(NUM_WR); j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
          r_mem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_RD); g++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_hit;
    logic [DATA_W-1:0] w_byp;

    assign w_addr = rd_addr[g*ADDR_W +: ADDR_W];

    // Same-cycle writeback forwarding; the youngest matching port wins.
    always_comb begin
      w_hit = 1'b0;
      w_byp = '0;
      for (int j = 0; j < int'(NUM_WR); j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == w_addr) && (w_addr != '0)) begin
          w_hit = 1'b1;
          w_byp = wr_data[j*DATA_W +: DATA_W];
        end
      end
    end

    assign rd_data[g*DATA_W +: DATA_W] = !rd_en[g]        ? '0 :
                                         w_hit            ? w_byp :
                                         (w_addr == '0)   ? '0 : r_mem[w_addr];
    assign rd_busy[g] = rd_en[g] & r_busy[w_addr] & ~w_hit;
  end

endmodule
